mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Load/store controller directly upstream of the 16x16 data memory: the sole driver of MemWrite/Addr/In and the sole consumer of Out.
- Accepts one load or store request from the execute stage over a valid/ready handshake and sequences exactly one memory access.
- Returns the result over a valid/ready response channel.
- Isolates pipeline timing from the memory's async-read / sync-write behaviour.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, processor-side address width.
- MEM_ADDR_W, 4, data memory address width (16 words).

Ports:
- Clk  in  1  system clock, all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  controller can accept a request.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqAddr  in  ADDR_W  word address.
- ReqData  in  DATA_W  store data.
- RespValid  out  1  response present.
- RespReady  in  1  consumer takes the response.
- RespData  out  DATA_W  load data; for a store, the stored word.
- RespErr  out  1  access rejected (see Optional Feature).
- MemWrite  out  1  data memory write enable.
- MemAddr  out  MEM_ADDR_W  data memory address.
- MemWData  out  DATA_W  data memory write data.
- MemRData  in  DATA_W  data memory combinational read data.

Behaviour:
- Single clock (Clk); synchronous active-high reset (Rst). Reset has priority over all other inputs.
- Reset values:
  - state IDLE.
  - ReqReady = 1 on the first cycle after Rst deasserts.
  - RespValid, RespErr, MemWrite = 0.
  - RespData, MemAddr, MemWData = 0.
  - All captured request registers = 0.
- FSM states IDLE, ACCESS, RESP:
  - IDLE: ReqReady = 1. On ReqValid, capture ReqWrite, ReqAddr, ReqData into registers, then go to ACCESS.
  - ACCESS: ReqReady = 0. MemAddr = captured ReqAddr[MEM_ADDR_W-1:0]. MemWData = captured data.
    - Store: MemWrite = 1 for exactly this one cycle; RespData <= captured data.
    - Load: MemWrite = 0; RespData <= MemRData sampled at the end of this cycle.
    - Always go to RESP next.
  - RESP: RespValid = 1, held with RespData/RespErr stable until RespReady is sampled high, then go to IDLE.
- Memory-side outputs:
  - Decoded from registered state only; no combinational path from Req* to Mem*.
  - MemWrite is additionally gated by ~Rst, so no write occurs in a reset cycle.
- Latency: request accepted at edge N; access during cycle N+1; RespValid high from N+2. With RespReady tied 1, the next request is accepted at N+3, giving 1 request per 3 cycles.
- Back-pressure:
  - RespReady low holds RESP indefinitely; ReqReady stays 0.
  - ReqValid while not in IDLE is ignored and must be held by the producer.
- Address wrap: only the low MEM_ADDR_W bits reach memory, so address 0x0013 accesses word 3 (unless the Optional Feature is enabled).
- Reset mid-operation: any state returns to IDLE next cycle, the pending response is discarded, and no memory write is issued in the reset cycle.
- No speculative reads: MemAddr holds its last value outside ACCESS.

Optional Feature:
- Macro: MEM_ACCESS_ADDR_CHECK_EN.
- Defined:
  - If the captured ReqAddr[ADDR_W-1:MEM_ADDR_W] is non-zero, ACCESS keeps MemWrite = 0.
  - RespData <= 0 and RespErr <= 1 for that response.
  - In-range accesses have RespErr = 0.
- Undefined:
  - Upper address bits are ignored (wrap as above).
  - RespErr is constant 0.
  - No check logic is synthesised.

Test Plan:
- Reset then load, addr 0x0002 (memory preloaded 0x0080), RespReady = 1 → RespValid exactly 2 cycles after acceptance, RespData = 0x0080, RespErr = 0, MemWrite never asserted.
- Store 0xBEEF to 0x0005, then load 0x0005 → MemWrite high exactly one cycle with MemAddr = 5, MemWData = 0xBEEF; store response RespData = 0xBEEF; load returns 0xBEEF.
- Load 0x0003 with RespReady held 0 for 5 cycles → RespValid and RespData = 0x0092 held stable, ReqReady = 0 throughout; a new ReqValid is ignored until the handshake completes.
- Store to 0x0007 with Rst asserted during ACCESS → MemWrite = 0 in that cycle, memory word 7 unchanged, RespValid never asserted, ReqReady = 1 after reset.
- Store 0x1234 to 0x0011:
  - Without the macro: writes word 1, and a load of 0x0001 returns 0x1234.
  - With MEM_ACCESS_ADDR_CHECK_EN: no write occurs, RespErr = 1, RespData = 0, word 1 is still 0x0001.
- Back-to-back loads of addresses 0..3 with ReqValid and RespReady held 1 → accepted every 3 cycles, responses 0x0000, 0x0001, 0x0080, 0x0092 in order.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer in front of the 16x16 data memory.
// Takes one request over a valid/ready handshake, performs exactly one memory
// access, then presents the result on a valid/ready response channel.
// Optional build macro: MEM_ACCESS_ADDR_CHECK_EN rejects requests whose
// address has non-zero bits above the memory index (RespErr = 1, no write).
module mem_access_ctrl #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int MEM_ADDR_W = 4
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  ReqValid,
   output logic                  ReqReady,
   input  logic                  ReqWrite,
   input  logic [ADDR_W-1:0]     ReqAddr,
   input  logic [DATA_W-1:0]     ReqData,
   output logic                  RespValid,
   input  logic                  RespReady,
   output logic [DATA_W-1:0]     RespData,
   output logic                  RespErr,
   output logic                  MemWrite,
   output logic [MEM_ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0]     MemWData,
   input  logic [DATA_W-1:0]     MemRData
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t             state, state_nxt;
   logic               cap_write;
   logic [ADDR_W-1:0]  cap_addr;
   logic [DATA_W-1:0]  cap_data;
   logic [DATA_W-1:0]  resp_data;
   logic               addr_ok;

`ifdef MEM_ACCESS_ADDR_CHECK_EN
   logic               resp_err;

   // Upper address bits must be clear for the access to reach memory.
   assign addr_ok = (cap_addr[ADDR_W-1:MEM_ADDR_W] == '0);
   assign RespErr = resp_err;

   // Error flag is produced alongside the response data in ACCESS.
   always_ff @(posedge Clk) begin
      if (Rst)                 resp_err <= 1'b0;
      else if (state == ACCESS) resp_err <= ~addr_ok;
   end
`else
   logic               unused_addr_hi;

   // Upper address bits are dropped: addresses wrap onto the 16 words.
   assign addr_ok        = 1'b1;
   assign RespErr        = 1'b0;
   assign unused_addr_hi = ^cap_addr[ADDR_W-1:MEM_ADDR_W];
`endif

   // State register.
   always_ff @(posedge Clk) begin
      if (Rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake/memory-side decode, all from registered state
   // so nothing on Req* reaches Mem* combinationally.
   always_comb begin
      state_nxt = state;
      ReqReady  = 1'b0;
      RespValid = 1'b0;
      MemWrite  = 1'b0;
      case (state)
         IDLE: begin
            ReqReady = 1'b1;
            if (ReqValid) state_nxt = ACCESS;
         end
         ACCESS: begin
            // Rst gating keeps a reset cycle from ever writing memory.
            MemWrite  = cap_write & addr_ok & ~Rst;
            state_nxt = RESP;
         end
         RESP: begin
            RespValid = 1'b1;
            if (RespReady) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture the request on acceptance; these also hold MemAddr/MemWData
   // steady outside ACCESS.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_data  <= '0;
      end else if (state == IDLE && ReqValid) begin
         cap_write <= ReqWrite;
         cap_addr  <= ReqAddr;
         cap_data  <= ReqData;
      end
   end

   // Response word: stored data for a store, sampled memory data for a load.
   always_ff @(posedge Clk) begin
      if (Rst)                   resp_data <= '0;
      else if (state == ACCESS) begin
         if (!addr_ok)           resp_data <= '0;
         else if (cap_write)     resp_data <= cap_data;
         else                    resp_data <= MemRData;
      end
   end

   assign MemAddr  = cap_addr[MEM_ADDR_W-1:0];
   assign MemWData = cap_data;
   assign RespData = resp_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed plus randomized load/store transactions checked
// against a word-array reference of the 16-entry data memory.
module tb_mem_access_ctrl;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        ReqValid = 1'b0;
   logic        ReqReady;
   logic        ReqWrite = 1'b0;
   logic [15:0] ReqAddr = '0;
   logic [15:0] ReqData = '0;
   logic        RespValid;
   logic        RespReady = 1'b0;
   logic [15:0] RespData;
   logic        RespErr;
   logic        MemWrite;
   logic [3:0]  MemAddr;
   logic [15:0] MemWData;
   logic [15:0] MemRData;

   logic [15:0] mem [16];
   logic [15:0] ref_mem [16];
   logic        load_mem = 1'b1;
   int          cyc = 0;
   int          wr_cnt = 0;
   logic [3:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   int          n_chk = 0;
   int          n_err = 0;
   int          last_acc = 0;

   mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .MEM_ADDR_W(4)) dut (
      .Clk(Clk), .Rst(Rst),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
      .ReqAddr(ReqAddr), .ReqData(ReqData),
      .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData), .RespErr(RespErr),
      .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] init_val(input int i);
      case (i)
         0: return 16'h0000;
         1: return 16'h0001;
         2: return 16'h0080;
         3: return 16'h0092;
         default: return 16'h1000 + 16'(i);
      endcase
   endfunction

   // Data memory: async read, sync write, preloaded while load_mem is high.
   always @(posedge Clk) begin
      if (load_mem) for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      else if (MemWrite) mem[MemAddr] <= MemWData;
   end
   assign MemRData = mem[MemAddr];

   always @(posedge Clk) cyc <= cyc + 1;

   // Record every memory write seen mid-cycle.
   always @(negedge Clk) begin
      if (MemWrite) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= MemAddr;
         wr_data <= MemWData;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One full transaction; hold = cycles RespReady stays low in RESP.
   task automatic xact(input bit w, input logic [15:0] a, input logic [15:0] d,
                       input int hold, input bit b2b,
                       output logic [15:0] rdata, output logic rerr);
      int t;
      int wc0;
      bit ok;
      logic [15:0] exp_d;
      ok = 1'b1;
`ifdef MEM_ACCESS_ADDR_CHECK_EN
      ok = (a[15:4] == 12'h0);
`endif
      exp_d = !ok ? 16'h0 : (w ? d : ref_mem[a[3:0]]);
      if (ok && w) ref_mem[a[3:0]] = d;
      ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqData = d;
      RespReady = (hold == 0);
      t = 0;
      while (!ReqReady && t < 10) begin @(posedge Clk); #1; t++; end
      chk("req_ready", 32'(ReqReady), 1);
      wc0 = wr_cnt;
      @(posedge Clk); #1;
      if (b2b) chk("b2b_gap", cyc - last_acc, 3);
      last_acc = cyc;
      // junk request while busy: must be ignored
      ReqWrite = 1'($urandom_range(0, 1)); ReqAddr = 16'($urandom); ReqData = 16'($urandom);
      chk("acc_ready", 32'(ReqReady), 0);
      chk("acc_rvalid", 32'(RespValid), 0);
      @(posedge Clk); #1;
      ReqValid = 1'b0;
      chk("resp_valid", 32'(RespValid), 1);
      for (int i = 0; i < hold; i++) begin
         ReqValid = 1'b1; ReqAddr = 16'($urandom); ReqData = 16'($urandom);
         @(posedge Clk); #1;
         chk("hold_valid", 32'(RespValid), 1);
         chk("hold_data", 32'(RespData), 32'(exp_d));
         chk("hold_ready", 32'(ReqReady), 0);
      end
      ReqValid = 1'b0;
      RespReady = 1'b1;
      chk("resp_data", 32'(RespData), 32'(exp_d));
      chk("resp_err", 32'(RespErr), 32'(!ok));
      rdata = RespData;
      rerr  = RespErr;
      @(posedge Clk); #1;
      chk("idle_ready", 32'(ReqReady), 1);
      chk("idle_rvalid", 32'(RespValid), 0);
      chk("wr_cnt", wr_cnt - wc0, (ok && w) ? 1 : 0);
      if (ok && w) begin
         chk("wr_addr", 32'(wr_addr), 32'(a[3:0]));
         chk("wr_data", 32'(wr_data), 32'(d));
      end
      if (hold != 0) RespReady = 1'b0;
   endtask

   initial begin
      logic [15:0] rd;
      logic        re;
      logic [15:0] b2b_tbl [4];
      int          wc0;
      bit          w;
      logic [15:0] a;
      b2b_tbl[0] = 16'h0000; b2b_tbl[1] = 16'h0001;
      b2b_tbl[2] = 16'h0080; b2b_tbl[3] = 16'h0092;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

      repeat (3) @(posedge Clk);
      #1;
      Rst = 1'b0; load_mem = 1'b0;
      chk("rst_req_ready", 32'(ReqReady), 1);
      chk("rst_resp_valid", 32'(RespValid), 0);
      chk("rst_resp_err", 32'(RespErr), 0);
      chk("rst_resp_data", 32'(RespData), 0);
      chk("rst_mem_write", 32'(MemWrite), 0);
      chk("rst_mem_addr", 32'(MemAddr), 0);
      chk("rst_mem_wdata", 32'(MemWData), 0);

      // back-to-back loads 0..3
      for (int i = 0; i < 4; i++) begin
         xact(1'b0, 16'(i), 16'h0, 0, i > 0, rd, re);
         chk("b2b_val", 32'(rd), 32'(b2b_tbl[i]));
      end

      xact(1'b0, 16'h0002, 16'h0, 0, 1'b0, rd, re);
      chk("load2", 32'(rd), 32'h0080);

      xact(1'b1, 16'h0005, 16'hBEEF, 0, 1'b0, rd, re);
      chk("store5_resp", 32'(rd), 32'hBEEF);
      xact(1'b0, 16'h0005, 16'h0, 0, 1'b0, rd, re);
      chk("load5", 32'(rd), 32'hBEEF);

      xact(1'b0, 16'h0003, 16'h0, 5, 1'b0, rd, re);
      chk("load3_hold", 32'(rd), 32'h0092);

      // reset during ACCESS of a store to word 7
      wc0 = wr_cnt;
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 16'h0007; ReqData = 16'hDEAD; RespReady = 1'b1;
      @(posedge Clk); #1;
      ReqValid = 1'b0; Rst = 1'b1;
      #1;
      chk("rstmid_memwrite", 32'(MemWrite), 0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      chk("rstmid_ready", 32'(ReqReady), 1);
      for (int i = 0; i < 3; i++) begin
         chk("rstmid_rvalid", 32'(RespValid), 0);
         @(posedge Clk); #1;
      end
      chk("rstmid_wr", wr_cnt - wc0, 0);
      chk("rstmid_mem7", 32'(mem[7]), 32'(ref_mem[7]));

      // out-of-range address 0x0011
      xact(1'b1, 16'h0011, 16'h1234, 0, 1'b0, rd, re);
`ifdef MEM_ACCESS_ADDR_CHECK_EN
      chk("oor_err", 32'(re), 1);
      chk("oor_data", 32'(rd), 0);
      xact(1'b0, 16'h0001, 16'h0, 0, 1'b0, rd, re);
      chk("oor_word1", 32'(rd), 32'h0001);
`else
      chk("wrap_err", 32'(re), 0);
      xact(1'b0, 16'h0001, 16'h0, 0, 1'b0, rd, re);
      chk("wrap_word1", 32'(rd), 32'h1234);
`endif

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         w = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         xact(w, a, 16'($urandom), int'($urandom_range(0, 3)), 1'b0, rd, re);
      end

      for (int i = 0; i < 16; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
